// File: rtl/Purple_Jade_pkg.sv
// Purple_Jade_pkg: shared widths, op record and M-stage state encoding for the load/store execute unit.
package Purple_Jade_pkg;
    localparam int WORD_SIZE_P  = 16;
    localparam int NUM_PHYS_REG = 64;
    localparam int ROB_ENTRY    = 32;
    localparam int SB_ENTRY     = 8;
    localparam int PT_W         = $clog2(NUM_PHYS_REG);
    localparam int RB_W         = $clog2(ROB_ENTRY);
    localparam int SB_W         = $clog2(SB_ENTRY);
    localparam int CDB_SB_WIDTH = SB_W + 2 * WORD_SIZE_P;

    typedef struct packed {
        logic                   is_store;
        logic [WORD_SIZE_P-1:0] addr;
        logic [WORD_SIZE_P-1:0] st_data;
        logic [PT_W-1:0]        rd;
        logic [RB_W-1:0]        rob;
        logic [SB_W-1:0]        sb_num;
    } lsu_op_t;

    typedef enum logic [1:0] {M_EMPTY, M_LIVE, M_HOLD} lsu_m_state_e;
endpackage

// File: rtl/lsu_wb_skid.sv
// lsu_wb_skid: M stage; selects bypass-or-memory data on the first cycle and parks it in a hold register on stall.
module lsu_wb_skid
    import Purple_Jade_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_v,
    output logic                   in_ready,
    input  logic                   in_is_store,
    input  logic [PT_W-1:0]        in_rd,
    input  logic [RB_W-1:0]        in_rob,
    input  logic                   in_pass_v,
    input  logic [WORD_SIZE_P-1:0] in_pass_val,
    input  logic [WORD_SIZE_P-1:0] mem_data,
    output logic                   out_v,
    input  logic                   out_ready,
    output logic                   out_is_store,
    output logic [PT_W-1:0]        out_rd,
    output logic [RB_W-1:0]        out_rob,
    output logic [WORD_SIZE_P-1:0] out_data
);
    lsu_m_state_e           state;
    logic                   pass_v;
    logic [WORD_SIZE_P-1:0] pass_val;
    logic [WORD_SIZE_P-1:0] hold_data;
    logic [WORD_SIZE_P-1:0] live_data;
    logic                   drain;

    // memory data is only valid in the first M cycle, so a stalled op must keep its own copy
    assign live_data = out_is_store ? '0 : pass_v ? pass_val : mem_data;
    assign out_v     = state != M_EMPTY && !flush;
    assign drain     = out_v && out_ready;
    assign in_ready  = state == M_EMPTY || drain;
    assign out_data  = state == M_HOLD ? hold_data : state == M_LIVE ? live_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= M_EMPTY;
            out_is_store <= 1'b0;
            out_rd       <= '0;
            out_rob      <= '0;
            pass_v       <= 1'b0;
            pass_val     <= '0;
            hold_data    <= '0;
        end else begin
            state <= flush ? M_EMPTY : in_v ? M_LIVE : (state == M_EMPTY || drain) ? M_EMPTY : M_HOLD;
            if (in_v) begin
                out_is_store <= in_is_store;
                out_rd       <= in_rd;
                out_rob      <= in_rob;
                pass_v       <= in_pass_v;
                pass_val     <= in_pass_val;
            end
            if (state == M_LIVE) hold_data <= live_data;
        end
    end
endmodule

// File: rtl/lsu_exe.sv
// lsu_exe: two-stage load/store execute unit (A: address gen and SB post, M: data select and write back).
module lsu_exe
    import Purple_Jade_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    rob_mispredict_i,
    input  logic                    issue_v_i,
    output logic                    issue_ready_o,
    input  logic                    issue_is_store_i,
    input  logic [WORD_SIZE_P-1:0]  issue_base_i,
    input  logic [WORD_SIZE_P-1:0]  issue_off_i,
    input  logic [WORD_SIZE_P-1:0]  issue_st_data_i,
    input  logic [PT_W-1:0]         issue_rd_i,
    input  logic [RB_W-1:0]         issue_rob_i,
    input  logic [SB_W-1:0]         issue_sb_num_i,
    output logic [WORD_SIZE_P-1:0]  exe_mem_addr_o,
    input  logic [WORD_SIZE_P-1:0]  exe_mem_data_i,
    output logic [WORD_SIZE_P-1:0]  exe_ld_bypass_addr_o,
    output logic [SB_W-1:0]         exe_ld_pass_sb_num_o,
    input  logic                    sb_ld_pass_valid_i,
    input  logic [WORD_SIZE_P-1:0]  sb_ld_pass_value_i,
    output logic                    exe_sb_v_o,
    output logic [CDB_SB_WIDTH-1:0] exe_sb_o,
    output logic                    wb_v_o,
    input  logic                    wb_ready_i,
    output logic                    wb_w_v_o,
    output logic [PT_W-1:0]         wb_rd_o,
    output logic [RB_W-1:0]         wb_rob_o,
    output logic [WORD_SIZE_P-1:0]  wb_data_o
);
    lsu_op_t a_op;
    logic    a_v;
    logic    a_adv;
    logic    m_ready;
    logic    accept;
    logic    m_is_store;

    assign a_adv         = a_v && m_ready && !rob_mispredict_i;
    assign issue_ready_o = !rob_mispredict_i && (!a_v || a_adv);
    assign accept        = issue_v_i && issue_ready_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            a_v  <= 1'b0;
            a_op <= '0;
        end else begin
            a_v <= !rob_mispredict_i && (accept || (a_v && !a_adv));
            if (accept) a_op <= '{is_store: issue_is_store_i, addr: issue_base_i + issue_off_i,
                                  st_data: issue_st_data_i, rd: issue_rd_i, rob: issue_rob_i,
                                  sb_num: issue_sb_num_i};
        end
    end

    assign exe_mem_addr_o       = a_v ? a_op.addr : '0;
    assign exe_ld_bypass_addr_o = exe_mem_addr_o;
    assign exe_ld_pass_sb_num_o = a_v ? a_op.sb_num : '0;
    // tied to the advancing edge so a stalled store posts exactly once
    assign exe_sb_v_o           = a_adv && a_op.is_store;
    assign exe_sb_o             = {a_op.sb_num, a_op.addr, a_op.st_data};
    assign wb_w_v_o             = wb_v_o && !m_is_store;

    lsu_wb_skid u_skid (
        .clk          (clk_i),
        .rst          (reset_i),
        .flush        (rob_mispredict_i),
        .in_v         (a_adv),
        .in_ready     (m_ready),
        .in_is_store  (a_op.is_store),
        .in_rd        (a_op.rd),
        .in_rob       (a_op.rob),
        .in_pass_v    (sb_ld_pass_valid_i),
        .in_pass_val  (sb_ld_pass_value_i),
        .mem_data     (exe_mem_data_i),
        .out_v        (wb_v_o),
        .out_ready    (wb_ready_i),
        .out_is_store (m_is_store),
        .out_rd       (wb_rd_o),
        .out_rob      (wb_rob_o),
        .out_data     (wb_data_o)
    );
endmodule

// File: tb/tb_lsu_exe.sv
// tb_lsu_exe: directed and random stimulus against a memory/store-buffer reference model with a completion scoreboard.
module tb_lsu_exe;
    import Purple_Jade_pkg::*;
    localparam int W = WORD_SIZE_P;

    logic clk = 0, reset_i, rob_mispredict_i, issue_v_i, issue_ready_o, issue_is_store_i;
    logic [W-1:0] issue_base_i, issue_off_i, issue_st_data_i;
    logic [PT_W-1:0] issue_rd_i, wb_rd_o;
    logic [RB_W-1:0] issue_rob_i, wb_rob_o;
    logic [SB_W-1:0] issue_sb_num_i, exe_ld_pass_sb_num_o;
    logic [W-1:0] exe_mem_addr_o, exe_ld_bypass_addr_o, sb_ld_pass_value_i, wb_data_o;
    logic [W-1:0] mem_q;
    logic sb_ld_pass_valid_i, exe_sb_v_o, wb_v_o, wb_ready_i, wb_w_v_o;
    logic [CDB_SB_WIDTH-1:0] exe_sb_o;

    logic [W-1:0] mem [65536];
    logic [W-1:0] sbv [65536];
    logic         hit [65536];

    typedef struct packed {
        logic            st;
        logic [PT_W-1:0] rd;
        logic [RB_W-1:0] rob;
        logic [W-1:0]    data;
        int              acc;
        logic            lat;
    } exp_t;
    exp_t wbq[$];
    logic [CDB_SB_WIDTH-1:0] sbq[$];

    int checks = 0, fails = 0, cyc = 0;
    logic chk_lat = 0, rst_d = 0, misp_d = 0, hold_pend = 0;
    logic [W-1:0] hold_data;
    logic [RB_W-1:0] hold_rob;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) mem_q <= mem[exe_mem_addr_o];
    assign sb_ld_pass_valid_i = hit[exe_ld_bypass_addr_o];
    assign sb_ld_pass_value_i = sbv[exe_ld_bypass_addr_o];

    lsu_exe dut (
        .clk_i(clk), .reset_i(reset_i), .rob_mispredict_i(rob_mispredict_i),
        .issue_v_i(issue_v_i), .issue_ready_o(issue_ready_o), .issue_is_store_i(issue_is_store_i),
        .issue_base_i(issue_base_i), .issue_off_i(issue_off_i), .issue_st_data_i(issue_st_data_i),
        .issue_rd_i(issue_rd_i), .issue_rob_i(issue_rob_i), .issue_sb_num_i(issue_sb_num_i),
        .exe_mem_addr_o(exe_mem_addr_o), .exe_mem_data_i(mem_q),
        .exe_ld_bypass_addr_o(exe_ld_bypass_addr_o), .exe_ld_pass_sb_num_o(exe_ld_pass_sb_num_o),
        .sb_ld_pass_valid_i(sb_ld_pass_valid_i), .sb_ld_pass_value_i(sb_ld_pass_value_i),
        .exe_sb_v_o(exe_sb_v_o), .exe_sb_o(exe_sb_o), .wb_v_o(wb_v_o), .wb_ready_i(wb_ready_i),
        .wb_w_v_o(wb_w_v_o), .wb_rd_o(wb_rd_o), .wb_rob_o(wb_rob_o), .wb_data_o(wb_data_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_note(input string name);
        checks++;
        fails++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // scoreboard monitor: push expectations on accept, pop on completion / SB post
    always @(negedge clk) begin
        exp_t e;
        logic [W-1:0] a;
        if (reset_i) begin
            if (rst_d) begin
                chk("rst_ready", issue_ready_o, 1);
                chk("rst_wb_v", wb_v_o, 0);
                chk("rst_sb_v", exe_sb_v_o, 0);
                chk("rst_w_v", wb_w_v_o, 0);
                chk("rst_data", wb_data_o, 0);
                chk("rst_addr", exe_mem_addr_o, 0);
            end
            wbq.delete();
            sbq.delete();
            hold_pend = 0;
        end else if (rob_mispredict_i) begin
            chk("misp_wb_v", wb_v_o, 0);
            chk("misp_sb_v", exe_sb_v_o, 0);
            chk("misp_ready", issue_ready_o, 0);
            wbq.delete();
            sbq.delete();
            hold_pend = 0;
        end else begin
            if (misp_d) begin
                chk("post_misp_wb_v", wb_v_o, 0);
                chk("post_misp_sb_v", exe_sb_v_o, 0);
                chk("post_misp_ready", issue_ready_o, 1);
            end
            if (hold_pend) begin
                chk("hold_v", wb_v_o, 1);
                chk("hold_data", wb_data_o, hold_data);
                chk("hold_rob", wb_rob_o, hold_rob);
            end
            if (exe_sb_v_o) begin
                if (sbq.size() == 0) fail_note("sb_extra_pulse");
                else chk("sb_pkt", exe_sb_o, sbq.pop_front());
            end
            if (wb_v_o && wb_ready_i) begin
                if (wbq.size() == 0) fail_note("wb_extra");
                else begin
                    e = wbq.pop_front();
                    chk("wb_w_v", wb_w_v_o, !e.st);
                    chk("wb_data", wb_data_o, e.data);
                    chk("wb_rob", wb_rob_o, e.rob);
                    if (!e.st) chk("wb_rd", wb_rd_o, e.rd);
                    if (e.lat) chk("wb_latency", cyc - e.acc, 2);
                end
            end
            hold_pend = wb_v_o && !wb_ready_i;
            hold_data = wb_data_o;
            hold_rob  = wb_rob_o;
            if (issue_v_i && issue_ready_o) begin
                a = issue_base_i + issue_off_i;
                e.st   = issue_is_store_i;
                e.rd   = issue_rd_i;
                e.rob  = issue_rob_i;
                e.data = issue_is_store_i ? '0 : hit[a] ? sbv[a] : mem[a];
                e.acc  = cyc;
                e.lat  = chk_lat;
                wbq.push_back(e);
                if (issue_is_store_i) sbq.push_back({issue_sb_num_i, a, issue_st_data_i});
            end
        end
        rst_d  = reset_i;
        misp_d = rob_mispredict_i;
    end

    task automatic set_op(input logic st, input logic [W-1:0] base, input logic [W-1:0] off,
                          input logic [W-1:0] data, input logic [PT_W-1:0] rd,
                          input logic [RB_W-1:0] rob, input logic [SB_W-1:0] sb);
        issue_v_i = 1; issue_is_store_i = st; issue_base_i = base; issue_off_i = off;
        issue_st_data_i = data; issue_rd_i = rd; issue_rob_i = rob; issue_sb_num_i = sb;
    endtask

    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (!issue_ready_o && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) fail_note("accept_timeout");
        @(posedge clk); #1;
    endtask

    task automatic send(input logic st, input logic [W-1:0] base, input logic [W-1:0] off,
                        input logic [W-1:0] data, input logic [PT_W-1:0] rd,
                        input logic [RB_W-1:0] rob, input logic [SB_W-1:0] sb);
        set_op(st, base, off, data, rd, rob, sb);
        wait_accept();
    endtask

    task automatic idle(input int n);
        issue_v_i = 0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = W'($urandom);
            sbv[i] = W'($urandom);
            hit[i] = ($urandom_range(0, 3) == 0);
        end
        reset_i = 1; rob_mispredict_i = 0; wb_ready_i = 1;
        set_op(0, 0, 0, 0, 0, 0, 0);
        issue_v_i = 0;
        repeat (3) @(posedge clk);
        #1 reset_i = 0;

        // plain load, memory data, fixed latency
        mem[16'h0104] = 16'hBEEF; hit[16'h0104] = 0; chk_lat = 1;
        send(0, 16'h0100, 16'h0004, 0, 7, 1, 0);
        idle(4);
        // store with address wrap
        send(1, 16'hFFFF, 16'h0002, 16'h1234, 0, 2, 3);
        idle(4);
        // SB hit beats memory, then back-to-back loads at full rate
        mem[16'h0200] = 0; hit[16'h0200] = 1; sbv[16'h0200] = 16'hCAFE;
        send(0, 16'h0200, 16'h0000, 0, 9, 3, 1);
        send(0, 16'h0300, 16'h0010, 0, 10, 4, 1);
        send(0, 16'h0400, 16'hFFF0, 0, 11, 5, 2);
        idle(4);
        chk_lat = 0;

        // three loads under a 3-cycle write-back stall
        wb_ready_i = 0;
        send(0, 16'h1000, 16'h0001, 0, 12, 6, 0);
        send(0, 16'h2000, 16'h0002, 0, 13, 7, 0);
        set_op(0, 16'h3000, 16'h0003, 0, 14, 8, 0);
        @(negedge clk);
        chk("ready_drop", issue_ready_o, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wb_ready_i = 1;
        wait_accept();
        idle(5);
        chk("t4_drained", wbq.size(), 0);

        // store stalled in A for two cycles posts once
        wb_ready_i = 0;
        send(0, 16'h4000, 16'h0004, 0, 15, 9, 0);
        send(1, 16'h5000, 16'h0005, 16'hA5A5, 0, 10, 5);
        idle(2);
        wb_ready_i = 1;
        idle(4);
        chk("t5_sb_done", sbq.size(), 0);

        // mispredict with both stages full, op offered in that cycle is dropped
        wb_ready_i = 0;
        send(0, 16'h6000, 16'h0006, 0, 16, 11, 0);
        send(1, 16'h7000, 16'h0007, 16'h5A5A, 0, 12, 6);
        rob_mispredict_i = 1;
        set_op(0, 16'h8000, 16'h0008, 0, 17, 13, 0);
        @(posedge clk); #1;
        rob_mispredict_i = 0; issue_v_i = 0; wb_ready_i = 1;
        idle(4);

        // reset while M holds a stalled load
        wb_ready_i = 0;
        send(0, 16'h9000, 16'h0009, 0, 18, 14, 0);
        idle(2);
        reset_i = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_i = 0; wb_ready_i = 1;
        idle(3);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            issue_v_i        = $urandom_range(0, 3) != 0;
            issue_is_store_i = $urandom_range(0, 2) == 0;
            issue_base_i     = W'($urandom);
            issue_off_i      = W'($urandom);
            issue_st_data_i  = W'($urandom);
            issue_rd_i       = PT_W'($urandom);
            issue_rob_i      = RB_W'($urandom);
            issue_sb_num_i   = SB_W'($urandom);
            rob_mispredict_i = $urandom_range(0, 49) == 0;
            wb_ready_i       = $urandom_range(0, 9) < 7;
            @(posedge clk); #1;
        end
        rob_mispredict_i = 0; wb_ready_i = 1;
        idle(10);
        chk("final_wbq_empty", wbq.size(), 0);
        chk("final_sbq_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
